// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_master
// Brief    : Byte-addressed load/store initiator for a word-organised data
//            memory; sub-word stores use read-modify-write.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_master #(
   parameter int unsigned MEM_WORDS = 10000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        done,
   output logic [31:0] rdata,
   output logic        err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_writeData,
   output logic        mem_memWrite,
   output logic        mem_memRead,
   input  logic [31:0] mem_readData
);

   localparam logic [31:0] c_mem_words = MEM_WORDS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_write;
   logic [1:0]  r_size;
   logic        r_signed;
   logic [1:0]  r_lane;
   logic [15:0] r_wdata;

   logic        w_accept;
   logic        w_bad;
   logic [4:0]  w_bsel;
   logic [4:0]  w_hsel;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_merged;
   logic [31:0] w_ext;

   assign req_ready = (r_state == IDLE);
   assign w_accept  = req_valid && req_ready;

   always_comb begin
      w_bad = (req_size == 2'b11)
           || ((req_size == 2'b01) && req_addr[0])
           || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
           || ({2'b00, req_addr[31:2]} >= c_mem_words);
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_bad)
                  w_next = DONE;
               else if (req_write && (req_size == 2'b10))
                  w_next = WR;
               else
                  w_next = RD;
            end
         end
         // A read phase is followed by a write only for sub-word stores
         RD:      w_next = r_write ? WR : DONE;
         WR:      w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Little-endian lane selection for merge and extension
   assign w_bsel = {r_lane, 3'b000};
   assign w_hsel = {r_lane[1], 4'b0000};
   assign w_byte = mem_readData[w_bsel +: 8];
   assign w_half = mem_readData[w_hsel +: 16];

   always_comb begin
      w_merged = mem_readData;
      if (r_size == 2'b00)
         w_merged[w_bsel +: 8] = r_wdata[7:0];
      else
         w_merged[w_hsel +: 16] = r_wdata;
   end

   always_comb begin
      case (r_size)
         2'b00:   w_ext = {{24{r_signed & w_byte[7]}}, w_byte};
         2'b01:   w_ext = {{16{r_signed & w_half[15]}}, w_half};
         default: w_ext = mem_readData;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_write       <= 1'b0;
         r_size        <= 2'b00;
         r_signed      <= 1'b0;
         r_lane        <= 2'b00;
         r_wdata       <= 16'h0000;
         done          <= 1'b0;
         err           <= 1'b0;
         rdata         <= 32'h0;
         mem_addr      <= 32'h0;
         mem_writeData <= 32'h0;
         mem_memRead   <= 1'b0;
         mem_memWrite  <= 1'b0;
      end else begin
         r_state      <= w_next;
         // Strobes and done follow the state being entered, one cycle each
         mem_memRead  <= (w_next == RD);
         mem_memWrite <= (w_next == WR);
         done         <= (w_next == DONE);
         if (w_accept) begin
            r_write  <= req_write;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_lane   <= req_addr[1:0];
            r_wdata  <= req_wdata[15:0];
            mem_addr <= {2'b00, req_addr[31:2]};
            err      <= w_bad;
            if (req_write && (req_size == 2'b10))
               mem_writeData <= req_wdata;
         end
         if (r_state == RD) begin
            if (r_write)
               mem_writeData <= w_merged;
            else
               rdata <= w_ext;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_master
// Brief    : Scoreboard bench for lsu_mem_master with a behavioural memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_master;

   localparam int c_words = 10000;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        done;
   logic [31:0] rdata;
   logic        err;
   logic [31:0] mem_addr;
   logic [31:0] mem_writeData;
   logic        mem_memWrite;
   logic        mem_memRead;
   logic [31:0] mem_readData;

   lsu_mem_master #(.MEM_WORDS(c_words)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_signed   (req_signed),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .done         (done),
      .rdata        (rdata),
      .err          (err),
      .mem_addr     (mem_addr),
      .mem_writeData(mem_writeData),
      .mem_memWrite (mem_memWrite),
      .mem_memRead  (mem_memRead),
      .mem_readData (mem_readData)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        chk_rd;
      logic        err;
      int          due;
      int          nstb;
      int          snap;
      logic [31:0] maddr;
   } exp_t;

   exp_t        sbq[$];
   exp_t        m_e;
   logic [31:0] mem [0:c_words-1];
   int          cyc = 0;
   int          strobes = 0;
   int          errors = 0;
   int          checks = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign mem_readData = (mem_addr < c_words) ? mem[mem_addr] : 32'h0;
   always @(posedge clk)
      if (mem_memWrite && (mem_addr < c_words)) mem[mem_addr] <= mem_writeData;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   // Monitor: strobe sanity and scoreboard pop on every done pulse
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_memRead || mem_memWrite) begin
            strobes++;
            chk("strobe_exclusive", {31'd0, mem_memRead & mem_memWrite}, 32'd0);
            if (sbq.size() != 0) chk("strobe_mem_addr", mem_addr, sbq[0].maddr);
         end
         if (done) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected no pending request");
            end else begin
               m_e = sbq.pop_front();
               chk("err", {31'd0, err}, {31'd0, m_e.err});
               chk("done_cycle", cyc, m_e.due);
               chk("strobe_count", strobes - m_e.snap, m_e.nstb);
               if (m_e.chk_rd) chk("rdata", rdata, m_e.rdata);
            end
         end
      end
   end

   task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic chk_rd, input logic [31:0] erd,
                        input logic eerr, input int lat, input int nstb);
      exp_t e;
      int   n;
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = wr;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got req_ready=0 expected 1 for addr %08h", a);
         req_valid = 1'b0;
         return;
      end
      e.rdata  = erd;
      e.chk_rd = chk_rd;
      e.err    = eerr;
      e.due    = cyc + lat;
      e.nstb   = nstb;
      e.snap   = strobes;
      e.maddr  = {2'b00, a[31:2]};
      sbq.push_back(e);
      @(posedge clk);
      #1;
      // Scramble the request fields to prove they were captured
      req_valid  = 1'b0;
      req_write  = ~wr;
      req_size   = ~sz;
      req_signed = ~sg;
      req_addr   = 32'hFFFF_FFFF;
      req_wdata  = 32'h0BAD_0BAD;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
         sbq.delete();
      end
   endtask

   initial begin
      for (int i = 0; i < c_words; i++) mem[i] = 32'h0;
      mem[16]   = 32'h1111_1111;
      mem[9999] = 32'h9999_0001;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_size   = 2'b00;
      req_signed = 1'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_strobes", {30'd0, mem_memRead, mem_memWrite}, 32'd0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_wdata", mem_writeData, 32'h0);
      rst_n = 1'b1;

      // Reset asserted mid-WR of a word store to 0x40
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
      req_addr = 32'h40; req_wdata = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("midwr_strobe_on", {31'd0, mem_memWrite}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("midwr_strobe_async_off", {31'd0, mem_memWrite}, 32'd0);
      chk("midwr_done_off", {31'd0, done}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midwr_ready_after", {31'd0, req_ready}, 32'd1);
      chk("midwr_mem16", mem[16], 32'h1111_1111);

      // Word store / load, byte RMW, sign and zero extension
      issue(1'b1, 2'b10, 1'b0, 32'h1000, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 2, 1);
      issue(1'b0, 2'b10, 1'b1, 32'h1000, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 2, 1);
      issue(1'b1, 2'b00, 1'b0, 32'h1002, 32'h1234_565A, 1'b0, 32'h0, 1'b0, 3, 2);
      drain();
      chk("sb_merged_word", mem[32'h400], 32'hDE5A_BEEF);
      issue(1'b0, 2'b00, 1'b1, 32'h1003, 32'h0, 1'b1, 32'hFFFF_FFDE, 1'b0, 2, 1);
      issue(1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 1'b1, 32'h0000_00DE, 1'b0, 2, 1);
      issue(1'b0, 2'b01, 1'b1, 32'h1000, 32'h0, 1'b1, 32'hFFFF_BEEF, 1'b0, 2, 1);
      issue(1'b0, 2'b01, 1'b0, 32'h1002, 32'h0, 1'b1, 32'h0000_DE5A, 1'b0, 2, 1);

      // Error cases leave rdata holding the previous load
      issue(1'b0, 2'b01, 1'b1, 32'h1001, 32'h0, 1'b1, 32'h0000_DE5A, 1'b1, 1, 0);
      issue(1'b1, 2'b10, 1'b0, 32'h1002, 32'h7777_7777, 1'b1, 32'h0000_DE5A, 1'b1, 1, 0);
      issue(1'b0, 2'b11, 1'b0, 32'h1000, 32'h0, 1'b1, 32'h0000_DE5A, 1'b1, 1, 0);
      issue(1'b0, 2'b10, 1'b0, 32'h9C40, 32'h0, 1'b1, 32'h0000_DE5A, 1'b1, 1, 0);
      issue(1'b0, 2'b10, 1'b0, 32'h9C3C, 32'h0, 1'b1, 32'h9999_0001, 1'b0, 2, 1);

      // Half store RMW, upper store bits must be ignored
      issue(1'b1, 2'b01, 1'b0, 32'h1000, 32'hFFFF_1234, 1'b0, 32'h0, 1'b0, 3, 2);
      drain();
      chk("sh_merged_word", mem[32'h400], 32'hDE5A_1234);
      chk("bad_store_no_write", mem[32'h400], 32'hDE5A_1234);

      // Second request held while the first is busy
      issue(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 1'b1, 32'hDE5A_1234, 1'b0, 2, 1);
      issue(1'b0, 2'b01, 1'b1, 32'h1000, 32'h0, 1'b1, 32'h0000_1234, 1'b0, 2, 1);
      drain();
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
